// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state type, default width and
// parity helper for the serial transmit shifter.
package serial_tx_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Even parity: XOR of every bit. Zero extension
  // does not change the result, so narrow words are
  // passed widened to 64 bits.
  function automatic logic even_parity(
    input logic [63:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/serial_tx_shift_if.sv
// serial_tx_shift_if: parallel load handshake plus
// serial line outputs of the transmit shifter.
interface serial_tx_shift_if
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             sdo_first;
  logic             busy;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  sdo,
    input  sdo_valid,
    input  sdo_first,
    input  busy
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output sdo,
    output sdo_valid,
    output sdo_first,
    output busy
  );

endinterface

// File: rtl/serial_tx_bitcnt.sv
// serial_tx_bitcnt: bit position counter for the
// transmit shifter, saturating at WIDTH-1.
module serial_tx_bitcnt
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  assign at_last = (cnt == CW'(WIDTH - 1));

  // Clear wins over increment; never steps past
  // the last bit position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx_shift.sv
// serial_tx_shift: parallel-in, serial-out MSB-first
// shifter. Optional parity bit: SERIAL_TX_PARITY_EN.
module serial_tx_shift
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  serial_tx_shift_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  assign accept  = bus.load_valid
                 && bus.load_ready;
  assign cnt_inc = (state == SHIFT);
  assign cnt_clr = accept
                 || (state != SHIFT)
                 || at_last;

  serial_tx_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .at_last (at_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a word ends on its last payload bit
  // (or the parity bit), where a new word may chain.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (at_last) begin
`ifdef SERIAL_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        state_nxt = accept ? SHIFT : IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only;
  // load_ready additionally gated by reset.
  always_comb begin
    bus.sdo        = 1'b0;
    bus.sdo_valid  = 1'b0;
    bus.sdo_first  = 1'b0;
    bus.busy       = 1'b0;
    bus.load_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.load_ready = 1'b1;
      end
      SHIFT: begin
        bus.sdo       = shreg[WIDTH-1];
        bus.sdo_valid = 1'b1;
        bus.sdo_first = (cnt == '0);
        bus.busy      = 1'b1;
`ifndef SERIAL_TX_PARITY_EN
        bus.load_ready = at_last;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        bus.sdo        = par_q;
        bus.sdo_valid  = 1'b1;
        bus.busy       = 1'b1;
        bus.load_ready = 1'b1;
      end
`endif
      default: begin
        bus.load_ready = 1'b0;
      end
    endcase
    if (rst) begin
      bus.load_ready = 1'b0;
    end
  end

  // Shift register: load on accept, else shift
  // left with zero fill while transmitting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= bus.load_data;
    end else if (state == SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity captured with the word so the shifted
  // register need not be kept intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= even_parity(64'(bus.load_data));
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx_shift.sv
// tb_serial_tx_shift: scoreboard bench for the serial
// transmit shifter with a loopback receiver.
module tb_serial_tx_shift;
  import serial_tx_pkg::*;

  localparam int W = DEFAULT_WIDTH;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = W + 1;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = W;
`endif

  typedef struct packed {
    logic b;
    logic first;
    logic last;
    logic pay;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t           expq[$];
  logic [W-1:0]   wq[$];
  logic [W-1:0]   rx;
  int             rx_n;

  serial_tx_shift_if #(.WIDTH(W)) bus ();

  serial_tx_shift #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm,
                      input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.b     = w[i];
      e.first = (i == W - 1);
      e.last  = (i == 0) && !PAR;
      e.pay   = 1'b1;
      expq.push_back(e);
    end
    if (PAR) begin
      e.b     = even_parity(64'(w));
      e.first = 1'b0;
      e.last  = 1'b1;
      e.pay   = 1'b0;
      expq.push_back(e);
    end
    wq.push_back(w);
  endtask

  task automatic send(input logic [W-1:0] w,
                      output int n);
    n = 0;
    @(negedge clk);
    bus.load_data  = w;
    bus.load_valid = 1'b1;
    while (!bus.load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", bus.load_ready, 1'b1);
    @(posedge clk);
    #1;
    push_word(w);
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || expq.size() != 0)
           && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("idle_wait", bus.busy, 1'b0);
  endtask

  // Monitor: pops one expected bit per valid cycle,
  // and feeds a serial-in receiver shifting at LSB.
  initial begin
    exp_t e;
    rx   = '0;
    rx_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        wq.delete();
        rx   = '0;
        rx_n = 0;
      end else if (bus.sdo_valid) begin
        chk1("busy_on", bus.busy, 1'b1);
        if (expq.size() == 0) begin
          chk1("unexpected_bit", bus.sdo_valid,
               1'b0);
        end else begin
          e = expq.pop_front();
          chk1("sdo", bus.sdo, e.b);
          chk1("sdo_first", bus.sdo_first, e.first);
          chk1("load_ready", bus.load_ready, e.last);
          if (e.pay) begin
            rx = {rx[W-2:0], bus.sdo};
            rx_n++;
            if (rx_n == W) begin
              rx_n = 0;
              if (wq.size() != 0) begin
                chkw("loopback", 32'(rx),
                     32'(wq.pop_front()));
              end
            end
          end
        end
      end else begin
        chk1("idle_sdo", bus.sdo, 1'b0);
        chk1("idle_first", bus.sdo_first, 1'b0);
        chk1("idle_busy", bus.busy, 1'b0);
        chk1("idle_ready", bus.load_ready, 1'b1);
      end
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    repeat (2) @(negedge clk);
    chk1("rst_sdo", bus.sdo, 1'b0);
    chk1("rst_valid", bus.sdo_valid, 1'b0);
    chk1("rst_first", bus.sdo_first, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready", bus.load_ready, 1'b0);
    rst = 1'b0;

    send(8'hA5, n);
    chkw("first_accept_wait", n, 0);
    wait_idle();

    send(8'h3C, n);
    wait_idle();

    @(negedge clk);
    bus.load_data  = 8'h3C;
    bus.load_valid = 1'b1;
    @(posedge clk);
    #1;
    push_word(8'h3C);
    bus.load_data = 8'hC3;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk1("b2b_valid_a", bus.sdo_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    push_word(8'hC3);
    bus.load_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk1("b2b_valid_b", bus.sdo_valid, 1'b1);
    end
    wait_idle();

    send(8'h5A, n);
    @(negedge clk);
    bus.load_data  = 8'hFF;
    bus.load_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    wait_idle();

    send(8'hF0, n);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk1("midrst_sdo", bus.sdo, 1'b0);
    chk1("midrst_valid", bus.sdo_valid, 1'b0);
    chk1("midrst_first", bus.sdo_first, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_ready", bus.load_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h81, n);
    chkw("post_rst_accept_wait", n, 0);
    wait_idle();

    send(8'h07, n);
    wait_idle();
    send(8'h03, n);
    wait_idle();

    repeat (2) @(negedge clk);
    chkw("queue_drained", expq.size(), 0);
    chkw("words_drained", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

endmodule
